// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin arbiter granting two masters one-cycle accesses to a single IO bus
//   clk, rst            : system clock, asynchronous active-high reset
//   m0_*/m1_* req/we/adr/wdata : master requests (held until acked)
//   m0_lock/m1_lock     : burst-lock requests, only with IOARB_LOCK_EN defined
//   m0_ack/m1_ack       : high for the owner's access cycle
//   m0_rdata/m1_rdata   : bus_spo routed to the owner, 0 for the other master
//   bus_we/bus_adr/bus_wdata : owner's request driven onto the IO bus, 0 when idle
//   bus_spo             : combinational read data from the IO bus
//   Optional feature macro: IOARB_LOCK_EN (adds lock ports and hold_cnt)
module iobus_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [15:2] m0_adr,
    input  logic [15:2] m1_adr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
`ifdef IOARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        bus_we,
    output logic [15:2] bus_adr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_spo
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state;
    state_t state_nx;
    state_t other;
    state_t pick;
    logic fav1;
    logic own_req;
    logic oth_req;
    logic stay;
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
        $error("MAX_HOLD must be within 1..15");
    end
    assign own_req = (state == OWN0) ? m0_req : m1_req;
    assign oth_req = (state == OWN0) ? m1_req : m0_req;
    assign other   = (state == OWN0) ? OWN1 : OWN0;
    // fav1 remembers that m0 was served last, so a tie goes to m1
    assign pick    = (m0_req && m1_req) ? (fav1 ? OWN1 : OWN0) : m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
`ifdef IOARB_LOCK_EN
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    // hold_cnt counts consecutive acks of the current owner, including the present one
    logic [3:0] hold_cnt;
    assign stay = ((state == OWN0) ? m0_lock : m1_lock) && own_req && (hold_cnt < HOLD_MAX);
`else
    assign stay = 1'b0;
`endif
    assign state_nx = (state == IDLE) ? pick : stay ? state : oth_req ? other : own_req ? state : IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fav1  <= 1'b0;
`ifdef IOARB_LOCK_EN
            hold_cnt <= 4'd0;
`endif
        end else begin
            state <= state_nx;
            if (state != IDLE) fav1 <= (state == OWN0);
`ifdef IOARB_LOCK_EN
            hold_cnt <= (state_nx == IDLE) ? 4'd0 : (state_nx != state) ? 4'd1 :
                        (hold_cnt < HOLD_MAX) ? hold_cnt + 4'd1 : hold_cnt;
`endif
        end
    end
    // outputs decode the state register, so rst clears them without waiting for clk
    assign m0_ack    = (state == OWN0);
    assign m1_ack    = (state == OWN1);
    assign bus_we    = m0_ack ? m0_we : (m1_ack & m1_we);
    assign bus_adr   = m0_ack ? m0_adr : m1_ack ? m1_adr : '0;
    assign bus_wdata = m0_ack ? m0_wdata : m1_ack ? m1_wdata : '0;
    assign m0_rdata  = m0_ack ? bus_spo : '0;
    assign m1_rdata  = m1_ack ? bus_spo : '0;
endmodule

// File: tb/tb_iobus_arbiter.sv
// tb_iobus_arbiter: directed vectors, corner sequences and randomized model check of iobus_arbiter
module tb_iobus_arbiter;
    localparam int MAX_HOLD = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [15:2] m0_adr = '0, m1_adr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
`ifdef IOARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    bit          lkv [2];
`endif
    logic        m0_ack, m1_ack, bus_we;
    logic [31:0] m0_rdata, m1_rdata, bus_wdata;
    logic [15:2] bus_adr;
    logic [31:0] bus_spo = '0;
    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [15:2] last_wadr = '0;
    logic [31:0] last_wdata = '0;
    int own = 0, prev = 0, last = 1, run = 0;
    bit rq [2], wv [2];
    logic [15:2] av [2];
    logic [31:0] dv [2];

    typedef struct {
        bit r0, r1, w0, w1;
        int own;
    } vec_t;
    vec_t tbl [10];
    int exp_seq [8];

    iobus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
`ifdef IOARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_spo(bus_spo)
    );

    always #5 clk = ~clk;

    // write log of the IO target: a write commits at the edge ending a cycle with bus_we high
    always @(posedge clk) begin
        if (bus_we) begin
            wr_cnt     <= wr_cnt + 1;
            last_wadr  <= bus_adr;
            last_wdata <= bus_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // o: 0 = nobody owns the bus, 1 = m0, 2 = m1
    task automatic check_own(input string tag, input int o);
        chk({tag, " m0_ack"}, 32'(m0_ack), 32'(o == 1));
        chk({tag, " m1_ack"}, 32'(m1_ack), 32'(o == 2));
        chk({tag, " bus_we"}, 32'(bus_we), 32'((o == 1) ? m0_we : (o == 2) ? m1_we : 1'b0));
        chk({tag, " bus_adr"}, 32'(bus_adr), 32'((o == 1) ? m0_adr : (o == 2) ? m1_adr : 14'h0));
        chk({tag, " bus_wdata"}, bus_wdata, (o == 1) ? m0_wdata : (o == 2) ? m1_wdata : 32'h0);
        chk({tag, " m0_rdata"}, m0_rdata, (o == 1) ? bus_spo : 32'h0);
        chk({tag, " m1_rdata"}, m1_rdata, (o == 2) ? bus_spo : 32'h0);
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_adr = '0; m1_adr = '0; m0_wdata = '0; m1_wdata = '0;
`ifdef IOARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
    endtask

    // returns at posedge+1 with the arbiter idle and no requests seen at that edge
    task automatic reset_dut();
        #1 rst = 1'b1;
        #1 check_own("reset", 0);
        clear_inputs();
        own = 0; prev = 0; last = 1; run = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v, input string tag);
        m0_req = v.r0; m1_req = v.r1; m0_we = v.w0; m1_we = v.w1;
        bus_spo = $urandom;
        @(negedge clk);
        check_own(tag, v.own);
        @(posedge clk);
        #1;
    endtask

    // reference: a locked owner keeps the bus for up to MAX_HOLD acks; otherwise a single
    // requester wins, and on a tie the master not served last wins
    task automatic advance();
        int nxt;
        bit lk;
        bit oreq;
        lk = 1'b0;
`ifdef IOARB_LOCK_EN
        lk = (own == 1) ? lkv[0] : lkv[1];
`endif
        oreq = (own == 1) ? m0_req : m1_req;
        prev = own;
        if (own != 0) last = own - 1;
        if (own != 0 && lk && oreq && run < MAX_HOLD) nxt = own;
        else if (m0_req && m1_req) nxt = (last == 0) ? 2 : 1;
        else if (m0_req) nxt = 1;
        else if (m1_req) nxt = 2;
        else nxt = 0;
        run = (nxt == 0) ? 0 : (nxt == own) ? run + 1 : 1;
        own = nxt;
    endtask

    task automatic random_stim();
        for (int x = 0; x < 2; x++) begin
            if (own == x + 1) rq[x] = ($urandom_range(0, 3) != 0);
            else if (prev == x + 1 || !rq[x]) begin
                rq[x] = 1'($urandom_range(0, 1));
                wv[x] = 1'($urandom_range(0, 1));
                av[x] = 14'($urandom);
                dv[x] = $urandom;
            end else if ($urandom_range(0, 7) == 0) rq[x] = 1'b0;
`ifdef IOARB_LOCK_EN
            lkv[x] = 1'($urandom_range(0, 1));
`endif
        end
        m0_req = rq[0]; m1_req = rq[1]; m0_we = wv[0]; m1_we = wv[1];
        m0_adr = av[0]; m1_adr = av[1]; m0_wdata = dv[0]; m1_wdata = dv[1];
`ifdef IOARB_LOCK_EN
        m0_lock = lkv[0]; m1_lock = lkv[1];
`endif
        bus_spo = $urandom;
    endtask

    initial begin
        int wc0;
        tbl[0] = '{1, 1, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 1, 1};
        tbl[2] = '{1, 1, 0, 1, 2};
        tbl[3] = '{1, 1, 0, 1, 1};
        tbl[4] = '{1, 0, 0, 1, 2};
        tbl[5] = '{1, 0, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 1, 1};
        tbl[7] = '{0, 1, 0, 1, 0};
        tbl[8] = '{0, 0, 0, 1, 2};
        tbl[9] = '{0, 0, 0, 0, 0};
`ifdef IOARB_LOCK_EN
        exp_seq = '{0, 1, 1, 1, 1, 2, 1, 1};
`else
        exp_seq = '{0, 1, 2, 1, 2, 1, 2, 1};
`endif

        // table: simultaneous requests after reset, drops during own ack, re-entry, idle returns
        reset_dut();
        m0_adr = 14'h0111; m1_adr = 14'h2222; m0_wdata = 32'hA0A0_0001; m1_wdata = 32'hB1B1_0002;
        for (int i = 0; i < 10; i++) run_row(tbl[i], $sformatf("vec%0d", i));

        // single m0 write: one ack cycle, one cycle after req, one committed write
        reset_dut();
        m0_req = 1; m0_we = 1; m0_adr = 14'h3C00; m0_wdata = 32'h1234_5678;
        @(negedge clk); check_own("wr_wait", 0);
        @(posedge clk); #1 m0_req = 0;
        @(negedge clk); check_own("wr_ack", 1);
        chk("wr_ack_we", 32'(bus_we), 32'h1);
        chk("wr_ack_adr", 32'(bus_adr), 32'h3C00);
        wc0 = wr_cnt;
        @(posedge clk); #1;
        @(negedge clk); check_own("wr_done", 0);
        chk("wr_count", 32'(wr_cnt), 32'(wc0 + 1));
        chk("wr_adr", 32'(last_wadr), 32'h3C00);
        chk("wr_data", last_wdata, 32'h1234_5678);

        // m1 read: bus data routed to m1 only
        @(posedge clk); #1;
        m1_req = 1; m1_we = 0; m1_adr = 14'h3C1C; bus_spo = 32'h00AB_CDEF;
        @(negedge clk); check_own("rd_wait", 0);
        @(posedge clk); #1 m1_req = 0;
        @(negedge clk); check_own("rd_ack", 2);
        chk("rd_m1_rdata", m1_rdata, 32'h00AB_CDEF);
        chk("rd_m0_rdata", m0_rdata, 32'h0);

        // reset in the middle of an m1 write: aborted, and m0 is favoured afterwards
        reset_dut();
        m1_req = 1; m1_we = 1; m1_adr = 14'h0055; m1_wdata = 32'hDEAD_BEEF;
        @(negedge clk); check_own("abort_wait", 0);
        @(posedge clk); #1;
        @(negedge clk); check_own("abort_own", 2);
        wc0 = wr_cnt;
        #1 rst = 1;
        #1 check_own("abort_rst", 0);
        #1 rst = 0;
        m0_req = 1;
        @(posedge clk); #1;
        @(negedge clk); check_own("abort_next", 1);
        chk("abort_no_write", 32'(wr_cnt), 32'(wc0));

        // both requesting continuously, m0 asking for a lock where the feature exists
        reset_dut();
        m0_req = 1; m1_req = 1; m0_we = 1; m0_adr = 14'h0AAA; m1_adr = 14'h0BBB;
        m0_wdata = 32'h0000_00AA; m1_wdata = 32'h0000_00BB;
`ifdef IOARB_LOCK_EN
        m0_lock = 1;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); check_own($sformatf("hold%0d", i), exp_seq[i]);
            @(posedge clk); #1;
        end

        // randomized traffic against the reference model, with occasional async resets
        reset_dut();
        for (int i = 0; i < 2; i++) rq[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            random_stim();
            @(negedge clk); check_own("rand", own);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1;
                #1 check_own("rand_rst", 0);
                rst = 0;
                own = 0; last = 1; run = 0;
            end
            @(posedge clk);
            advance();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive locked grants to one master; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have ports m0_req, m1_req  input  1 each  access request from master 0 (CPU data port) and master 1 (loader/debug).
REQ-005 The block SHALL have ports m0_we, m1_we  input  1 each  write enable of the request.
REQ-006 The block SHALL have ports m0_adr, m1_adr  input  [15:2] each  word address.
REQ-007 The block SHALL have ports m0_wdata, m1_wdata  input  32 each  write data.
REQ-008 The block SHALL have ports m0_lock, m1_lock  input  1 each  burst-lock request; present only when IOARB_LOCK_EN is defined.
REQ-009 The block SHALL have ports m0_ack, m1_ack  output  1 each  access completes at the next rising edge.
REQ-010 The block SHALL have ports m0_rdata, m1_rdata  output  32 each  read data, valid while the matching ack is high.
REQ-011 The block SHALL have ports bus_we  output  1, bus_adr  output  [15:2], bus_wdata  output  32  toward the IO bus.
REQ-012 The block SHALL have port bus_spo  input  32  combinational read data from the IO bus.

Function
REQ-013 The FSM SHALL have states IDLE, OWN0, OWN1; ack for a master is high exactly while the FSM is in that master's OWN state.
REQ-014 In OWNx, the bus outputs SHALL equal mx_we, mx_adr and mx_wdata; mx_rdata SHALL equal bus_spo combinationally; the other master's rdata SHALL be 0.
REQ-015 In IDLE, bus_we, bus_adr and bus_wdata SHALL all be 0, and both acks SHALL be 0.
REQ-016 A requester SHALL keep req, we, adr and wdata stable until its ack is sampled high; one ack cycle SHALL equal one completed access (the write commits at the edge ending the ack cycle).
REQ-017 Latency SHALL be one cycle: a req sampled in IDLE at edge N moves the FSM to OWNx, and ack is high in cycle N+1.
REQ-018 A round-robin pointer SHALL be used: when both masters request, the grant SHALL go to the master not served last; the pointer SHALL update on every OWN exit.
REQ-019 Leaving OWNx with the other master requesting SHALL go directly to OWN(other); this gives back-to-back accesses with no IDLE cycle.
REQ-020 Leaving OWNx with only mx requesting SHALL re-enter OWNx.
REQ-021 Leaving OWNx with no request SHALL return to IDLE.
REQ-022 Req deasserted during a master's own ack cycle SHALL be legal; the access still completes at that edge.
REQ-023 A req dropped before its grant SHALL be ignored, with no bus activity for that master.

Reset
REQ-024 Asserting rst SHALL immediately force the FSM to IDLE, the pointer to favour m0, and hold_cnt to 0, independent of clk.
REQ-025 Because of REQ-024, bus_we and both acks SHALL drop to 0 combinationally on rst.
REQ-026 If rst is asserted during OWNx, the write for that cycle SHALL NOT commit.
REQ-027 After rst deasserts, the first arbitration SHALL occur at the next rising edge.

Configuration
REQ-028 Macro IOARB_LOCK_EN defined: while the owner holds mx_lock and mx_req at the end of its ack cycle, the FSM SHALL stay in OWNx regardless of the other master's request, for at most MAX_HOLD consecutive acks counted by a 4-bit hold_cnt.
REQ-029 With IOARB_LOCK_EN defined: when hold_cnt reaches MAX_HOLD, the owner SHALL release the bus if the other master requests; hold_cnt SHALL clear on any change of owner or on IDLE.
REQ-030 Macro IOARB_LOCK_EN undefined: the lock ports, hold_cnt and the lock logic SHALL be absent, and arbitration SHALL be pure round-robin.

Verification
REQ-031 Reset, then m0 writes adr 0x3C00 (byte 0xF000), wdata 0x12345678 -> m0_ack high exactly one cycle, one cycle after req; bus_we=1 in that cycle; bus shows adr 0x3C00.
REQ-032 m0 and m1 request in the same IDLE cycle after reset -> order OWN0, OWN1, OWN0, ...; acks alternate every cycle; no IDLE cycle while both hold req.
REQ-033 m1 reads adr 0x3C1C while the bus returns 0x00ABCDEF -> m1_rdata=0x00ABCDEF during m1_ack; m0_rdata=0.
REQ-034 rst pulsed mid-OWN1 with m1_we=1 -> bus_we=0 and m1_ack=0 immediately; target register unchanged; next grant after release goes to m0.
REQ-035 IOARB_LOCK_EN, MAX_HOLD=4, m0_lock=1, both requesting -> exactly 4 consecutive m0 acks, then m1_ack.
REQ-036 IOARB_LOCK_EN undefined, same stimulus as REQ-035 -> m0 and m1 acks alternate each cycle.
